dmem_lsu: RTL and testbench

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu_if.sv | 22 ++
 rtl/dmem_lsu.sv | 165 ++++++++++++++++
 tb/tb_dmem_lsu.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the memory port (slave).
// One request at a time; reads return on dmRvalid.
interface dmem_lsu_if;
  logic        dmReq;
  logic        dmWe;
  logic [31:0] dmAddr;
  logic [3:0]  dmBe;
  logic [31:0] dmWdata;
  logic        dmGnt;
  logic        dmRvalid;
  logic [31:0] dmRdata;

  modport master (
    output dmReq, dmWe, dmAddr, dmBe, dmWdata,
    input  dmGnt, dmRvalid, dmRdata
  );

  modport slave (
    input  dmReq, dmWe, dmAddr, dmBe, dmWdata,
    output dmGnt, dmRvalid, dmRdata
  );
endinterface

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: issues one aligned byte/half/word access at a time,
// stalls the pipeline while waiting, and returns the extended load result in WB.
module dmem_lsu (
  input  logic        clk,
  input  logic        arstn,
  input  logic        memReqMEM,
  input  logic        memWeMEM,
  input  logic [1:0]  memSizeMEM,
  input  logic        memUnsignedMEM,
  input  logic [31:0] memAddrMEM,
  input  logic [31:0] memWdataMEM,
  output logic        stallMEM,
  output logic        misalignedMEM,
  output logic [31:0] dmLoadData,
  output logic        loadValidWB,
  dmem_lsu_if.master  dm
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q;
  logic [3:0]  req_be_q;
  logic        req_we_q;
  logic [31:0] req_wdata_q;
  logic [1:0]  req_size_q;
  logic        req_uns_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;

  logic        misaligned;
  logic        accept;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  always_comb begin
    misaligned = 1'b0;
    be_in      = 4'b1111;
    wdata_in   = memWdataMEM;
    case (memSizeMEM)
      2'b00: begin
        be_in    = 4'b0001 << memAddrMEM[1:0];
        wdata_in = {4{memWdataMEM[7:0]}};
      end
      2'b01: begin
        misaligned = memAddrMEM[0];
        be_in      = memAddrMEM[1] ? 4'b1100 : 4'b0011;
        wdata_in   = {2{memWdataMEM[15:0]}};
      end
      2'b10:   misaligned = |memAddrMEM[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign accept = (state_q == IDLE) && memReqMEM && !misaligned;

  // Lane selection uses the latched offset: the MEM inputs may have moved on by now.
  always_comb begin
    byte_lane = dm.dmRdata[8*req_addr_q[1:0] +: 8];
    half_lane = req_addr_q[1] ? dm.dmRdata[31:16] : dm.dmRdata[15:0];
    case (req_size_q)
      2'b00:   load_ext = {{24{byte_lane[7] & ~req_uns_q}}, byte_lane};
      2'b01:   load_ext = {{16{half_lane[15] & ~req_uns_q}}, half_lane};
      default: load_ext = dm.dmRdata;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!dm.dmGnt)     state_d = WAIT_GNT;
          else if (!memWeMEM) state_d = WAIT_RVALID;
        end
      end
      WAIT_GNT: begin
        if (dm.dmGnt) state_d = req_we_q ? IDLE : WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (dm.dmRvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The request is visible in its first cycle straight from the MEM inputs;
  // arstn gating keeps the bus quiet while reset is held.
  always_comb begin
    dm.dmReq      = 1'b0;
    dm.dmWe       = 1'b0;
    dm.dmAddr     = 32'h0;
    dm.dmBe       = 4'b0000;
    dm.dmWdata    = 32'h0;
    stallMEM      = 1'b0;
    misalignedMEM = 1'b0;
    if (arstn) begin
      case (state_q)
        IDLE: begin
          if (memReqMEM && misaligned) begin
            misalignedMEM = 1'b1;
          end else if (memReqMEM) begin
            dm.dmReq   = 1'b1;
            dm.dmWe    = memWeMEM;
            dm.dmAddr  = {memAddrMEM[31:2], 2'b00};
            dm.dmBe    = be_in;
            dm.dmWdata = wdata_in;
            stallMEM   = !(dm.dmGnt && memWeMEM);
          end
        end
        WAIT_GNT: begin
          dm.dmReq   = 1'b1;
          dm.dmWe    = req_we_q;
          dm.dmAddr  = {req_addr_q[31:2], 2'b00};
          dm.dmBe    = req_be_q;
          dm.dmWdata = req_wdata_q;
          stallMEM   = !(dm.dmGnt && req_we_q);
        end
        WAIT_RVALID: stallMEM = !dm.dmRvalid;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      req_addr_q   <= 32'h0;
      req_be_q     <= 4'b0000;
      req_we_q     <= 1'b0;
      req_wdata_q  <= 32'h0;
      req_size_q   <= 2'b00;
      req_uns_q    <= 1'b0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        req_addr_q  <= memAddrMEM;
        req_be_q    <= be_in;
        req_we_q    <= memWeMEM;
        req_wdata_q <= wdata_in;
        req_size_q  <= memSizeMEM;
        req_uns_q   <= memUnsignedMEM;
      end
      load_valid_q <= (state_q == WAIT_RVALID) && dm.dmRvalid;
      if ((state_q == WAIT_RVALID) && dm.dmRvalid) begin
        load_data_q <= load_ext;
      end
    end
  end

  assign dmLoadData  = load_data_q;
  assign loadValidWB = load_valid_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a transaction-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_dmem_lsu;

  logic        clk;
  logic        arstn;
  logic        memReqMEM;
  logic        memWeMEM;
  logic [1:0]  memSizeMEM;
  logic        memUnsignedMEM;
  logic [31:0] memAddrMEM;
  logic [31:0] memWdataMEM;
  logic        stallMEM;
  logic        misalignedMEM;
  logic [31:0] dmLoadData;
  logic        loadValidWB;

  dmem_lsu_if bus ();

  dmem_lsu dut (
    .clk            (clk),
    .arstn          (arstn),
    .memReqMEM      (memReqMEM),
    .memWeMEM       (memWeMEM),
    .memSizeMEM     (memSizeMEM),
    .memUnsignedMEM (memUnsignedMEM),
    .memAddrMEM     (memAddrMEM),
    .memWdataMEM    (memWdataMEM),
    .stallMEM       (stallMEM),
    .misalignedMEM  (misalignedMEM),
    .dmLoadData     (dmLoadData),
    .loadValidWB    (loadValidWB),
    .dm             (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (access-level view) ----------------
  function automatic logic bad_align(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd2 && (a % 4) != 0) || (sz == 2'd1 && (a % 2) != 0);
  endfunction

  function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'b0001 << (a % 4);
    if (sz == 2'd1) return 4'b0011 << (a % 4);
    return 4'b1111;
  endfunction

  function automatic logic [31:0] repl(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return {4{w[7:0]}};
    if (sz == 2'd1) return {2{w[15:0]}};
    return w;
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] sz, input logic uns,
                                          input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (a % 4 == 2) ? (rd >> 16) : (rd & 32'hFFFF);
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  logic        m_busy, m_granted, m_we, m_uns, m_lv;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_ld;

  always @(negedge clk) begin
    logic        e_req, e_we, e_stall, e_mis, n_lv;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd, n_ld;
    if (!arstn) begin
      m_busy = 0; m_granted = 0; m_we = 0; m_uns = 0; m_size = 0;
      m_addr = 0; m_wdata = 0; m_ld = 0; m_lv = 0;
      chk("rst_dmReq", bus.dmReq, 0);
      chk("rst_dmWe", bus.dmWe, 0);
      chk("rst_dmBe", bus.dmBe, 0);
      chk("rst_dmAddr", bus.dmAddr, 0);
      chk("rst_dmWdata", bus.dmWdata, 0);
      chk("rst_stall", stallMEM, 0);
      chk("rst_misaligned", misalignedMEM, 0);
      chk("rst_loadValid", loadValidWB, 0);
      chk("rst_loadData", dmLoadData, 0);
    end else begin
      e_req = 0; e_we = 0; e_stall = 0; e_mis = 0; e_be = 0; e_addr = 0; e_wd = 0;
      n_lv = 0; n_ld = m_ld;
      if (!m_busy) begin
        if (memReqMEM) begin
          if (bad_align(memSizeMEM, memAddrMEM)) begin
            e_mis = 1;
          end else begin
            e_req   = 1;
            e_we    = memWeMEM;
            e_addr  = memAddrMEM & ~32'h3;
            e_be    = lanes(memSizeMEM, memAddrMEM);
            e_wd    = repl(memSizeMEM, memWdataMEM);
            e_stall = !(bus.dmGnt && memWeMEM);
            if (e_stall) begin
              m_busy = 1; m_granted = bus.dmGnt; m_we = memWeMEM; m_uns = memUnsignedMEM;
              m_size = memSizeMEM; m_addr = memAddrMEM; m_wdata = memWdataMEM;
            end
          end
        end
      end else if (!m_granted) begin
        e_req   = 1;
        e_we    = m_we;
        e_addr  = m_addr & ~32'h3;
        e_be    = lanes(m_size, m_addr);
        e_wd    = repl(m_size, m_wdata);
        e_stall = !(bus.dmGnt && m_we);
        if (bus.dmGnt) begin
          if (m_we) m_busy = 0;
          else      m_granted = 1;
        end
      end else begin
        e_stall = !bus.dmRvalid;
        if (bus.dmRvalid) begin
          m_busy = 0; m_granted = 0;
          n_lv = 1;
          n_ld = extract(m_size, m_uns, m_addr, bus.dmRdata);
        end
      end
      chk("model_dmReq", bus.dmReq, e_req);
      chk("model_stall", stallMEM, e_stall);
      chk("model_misaligned", misalignedMEM, e_mis);
      chk("model_loadValid", loadValidWB, m_lv);
      chk("model_loadData", dmLoadData, m_ld);
      if (e_req) begin
        chk("model_dmWe", bus.dmWe, e_we);
        chk("model_dmAddr", bus.dmAddr, e_addr);
        chk("model_dmBe", bus.dmBe, e_be);
        chk("model_dmWdata", bus.dmWdata, e_wd);
      end
      m_lv = n_lv;
      m_ld = n_ld;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input logic r, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
    memReqMEM = r; memWeMEM = we; memSizeMEM = sz;
    memUnsignedMEM = uns; memAddrMEM = a; memWdataMEM = wd;
  endtask

  task automatic setbus(input logic g, input logic rv, input logic [31:0] rd);
    bus.dmGnt = g; bus.dmRvalid = rv; bus.dmRdata = rd;
  endtask

  int stall_cnt;
  int req_cnt;

  initial begin
    arstn = 1'b1;
    setreq(0, 0, 0, 0, 0, 0);
    setbus(0, 0, 0);
    #2 arstn = 1'b0;
    setreq(1, 1, 2'd2, 0, 32'h0000_0010, 32'h1234_5678);
    @(negedge clk);
    $display("txn: reset with aligned request pending");
    chk("reset_dmReq", bus.dmReq, 0);
    chk("reset_stall", stallMEM, 0);
    chk("reset_dmBe", bus.dmBe, 0);
    chk("reset_loadData", dmLoadData, 0);

    step(); arstn = 1'b1; setreq(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // store byte with immediate grant
    step(); setreq(1, 1, 2'd0, 0, 32'h1003, 32'hAB); setbus(1, 0, 0);
    @(negedge clk);
    $display("txn: store byte 0x1003");
    chk("sb_dmReq", bus.dmReq, 1);
    chk("sb_dmAddr", bus.dmAddr, 32'h1000);
    chk("sb_dmBe", bus.dmBe, 4'b1000);
    chk("sb_dmWdata", bus.dmWdata, 32'hABAB_ABAB);
    chk("sb_stall", stallMEM, 0);

    // signed half load, grant two cycles late
    step(); setreq(1, 0, 2'd1, 0, 32'h2002, 0); setbus(0, 0, 0);
    @(negedge clk);
    $display("txn: load half signed 0x2002");
    chk("lh_dmBe", bus.dmBe, 4'b1100);
    chk("lh_dmAddr", bus.dmAddr, 32'h2000);
    stall_cnt = int'(stallMEM);
    step(); @(negedge clk); stall_cnt += int'(stallMEM);
    step(); setbus(1, 0, 0); @(negedge clk); stall_cnt += int'(stallMEM);
    step(); setbus(0, 1, 32'h8001_1234); @(negedge clk);
    chk("lh_stall_end", stallMEM, 0);
    chk("lh_dmReq_rvalid", bus.dmReq, 0);
    chk("lh_stall_cycles", stall_cnt, 3);
    step(); setreq(0, 0, 0, 0, 0, 0); setbus(0, 0, 0); @(negedge clk);
    chk("lh_loadValid", loadValidWB, 1);
    chk("lh_loadData", dmLoadData, 32'hFFFF_8001);

    // unsigned byte load
    step(); setreq(1, 0, 2'd0, 1, 32'h11, 0); setbus(1, 0, 0); @(negedge clk);
    $display("txn: load byte unsigned 0x11");
    chk("lbu_dmBe", bus.dmBe, 4'b0010);
    chk("lbu_stall", stallMEM, 1);
    step(); setreq(0, 0, 0, 0, 0, 0); setbus(0, 1, 32'h0000_F000); @(negedge clk);
    step(); setbus(0, 0, 0); @(negedge clk);
    chk("lbu_loadData", dmLoadData, 32'h0000_00F0);
    chk("lbu_loadValid", loadValidWB, 1);
    step(); @(negedge clk);
    chk("lbu_loadValid_pulse", loadValidWB, 0);
    chk("lbu_loadData_hold", dmLoadData, 32'h0000_00F0);

    // misaligned accesses (grant offered but must be ignored)
    step(); setreq(1, 0, 2'd2, 0, 32'h6, 0); setbus(1, 0, 0); @(negedge clk);
    $display("txn: misaligned word 0x6");
    chk("mis_w_flag", misalignedMEM, 1);
    chk("mis_w_dmReq", bus.dmReq, 0);
    chk("mis_w_stall", stallMEM, 0);
    step(); setreq(1, 0, 2'd1, 0, 32'h5, 0); @(negedge clk);
    $display("txn: misaligned half 0x5");
    chk("mis_h_flag", misalignedMEM, 1);
    chk("mis_h_dmReq", bus.dmReq, 0);
    step(); setreq(1, 1, 2'd3, 0, 32'h0, 32'h55); @(negedge clk);
    $display("txn: reserved size");
    chk("mis_rsv_flag", misalignedMEM, 1);
    step(); setreq(0, 0, 0, 0, 0, 0); setbus(0, 0, 0); @(negedge clk);
    chk("mis_clear", misalignedMEM, 0);

    // store half with late grant; MEM inputs change while held
    step(); setreq(1, 1, 2'd1, 0, 32'h2, 32'h1234_5678); @(negedge clk);
    $display("txn: store half 0x2, late grant");
    chk("sh_dmWdata", bus.dmWdata, 32'h5678_5678);
    chk("sh_stall", stallMEM, 1);
    step(); setreq(1, 0, 2'd0, 0, 32'h7, 32'hFFFF_FFFF); setbus(1, 0, 0); @(negedge clk);
    chk("sh_hold_dmWdata", bus.dmWdata, 32'h5678_5678);
    chk("sh_hold_dmBe", bus.dmBe, 4'b1100);
    chk("sh_hold_dmWe", bus.dmWe, 1);
    chk("sh_stall_end", stallMEM, 0);
    step(); setreq(0, 0, 0, 0, 0, 0); setbus(0, 0, 0); @(negedge clk);

    // signed byte load at offset 3
    step(); setreq(1, 0, 2'd0, 0, 32'h3, 0); setbus(1, 0, 0); @(negedge clk);
    $display("txn: load byte signed 0x3");
    step(); setreq(0, 0, 0, 0, 0, 0); setbus(0, 1, 32'h8000_0000); @(negedge clk);
    step(); setbus(0, 0, 0); @(negedge clk);
    chk("lb_loadData", dmLoadData, 32'hFFFF_FF80);

    // unsigned half load at offset 0
    step(); setreq(1, 0, 2'd1, 1, 32'h40, 0); setbus(1, 0, 0); @(negedge clk);
    $display("txn: load half unsigned 0x40");
    step(); setreq(0, 0, 0, 0, 0, 0); setbus(0, 1, 32'h5555_9ABC); @(negedge clk);
    step(); setbus(0, 0, 0); @(negedge clk);
    chk("lhu_loadData", dmLoadData, 32'h0000_9ABC);

    // stray rvalid while idle
    step(); setbus(0, 1, 32'h1234_5678); @(negedge clk);
    $display("txn: stray rvalid in idle");
    step(); setbus(0, 0, 0); @(negedge clk);
    chk("stray_loadValid", loadValidWB, 0);
    chk("stray_loadData", dmLoadData, 32'h0000_9ABC);

    // reset while waiting for read data, late rvalid afterwards
    step(); setreq(1, 0, 2'd2, 0, 32'h100, 0); setbus(1, 0, 0); @(negedge clk);
    $display("txn: load word 0x100 abandoned by reset");
    step(); setreq(0, 0, 0, 0, 0, 0); setbus(0, 0, 0); @(negedge clk);
    chk("rstw_stall", stallMEM, 1);
    step(); arstn = 1'b0; @(negedge clk);
    chk("rstw_stall_rst", stallMEM, 0);
    chk("rstw_loadData_rst", dmLoadData, 0);
    step(); arstn = 1'b1; setbus(0, 1, 32'hDEAD_BEEF); @(negedge clk);
    chk("rstw_stall_after", stallMEM, 0);
    step(); setbus(0, 0, 0); @(negedge clk);
    chk("rstw_loadValid", loadValidWB, 0);
    chk("rstw_loadData", dmLoadData, 0);

    // back-to-back store then load
    step(); setreq(1, 1, 2'd2, 0, 32'h40, 32'h1122_3344); setbus(1, 0, 0); @(negedge clk);
    $display("txn: store word 0x40 then load word 0x44");
    req_cnt = int'(bus.dmReq);
    chk("b2b_store_stall", stallMEM, 0);
    step(); setreq(1, 0, 2'd2, 0, 32'h44, 0); @(negedge clk);
    req_cnt += int'(bus.dmReq);
    chk("b2b_load_dmAddr", bus.dmAddr, 32'h44);
    chk("b2b_load_stall", stallMEM, 1);
    step(); setreq(0, 0, 0, 0, 0, 0); setbus(0, 0, 0); @(negedge clk);
    req_cnt += int'(bus.dmReq);
    chk("b2b_wait_stall", stallMEM, 1);
    step(); setbus(0, 1, 32'hCAFE_F00D); @(negedge clk);
    req_cnt += int'(bus.dmReq);
    chk("b2b_rvalid_stall", stallMEM, 0);
    chk("b2b_req_cycles", req_cnt, 2);
    step(); setbus(0, 0, 0); @(negedge clk);
    chk("b2b_loadValid", loadValidWB, 1);
    chk("b2b_loadData", dmLoadData, 32'hCAFE_F00D);

    step(); @(negedge clk);
    step(); @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
